// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII TX shim.
package gmii_pkg;

  localparam int GMII_DW    = 8;
  localparam int LINK_BIT   = 0;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } tx_state_e;

  function automatic logic stages_legal(input int s);
    return (s >= STAGES_MIN) && (s <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/gmii_sat_counter.sv
// Saturating event counter; a clear wins over a same-cycle increment.
module gmii_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             userclk2,
  input  logic             sys0_rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge userclk2 or posedge sys0_rst) begin
    if (sys0_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gmii_tx_shim.sv
// MAC-to-PCS GMII TX shim: whole-frame gating, STAGES-deep retiming,
// registered PCS status with sticky bits, frame and link-drop statistics.
module gmii_tx_shim
  import gmii_pkg::*;
#(
  parameter int STAGES = 1,
  parameter int DW     = GMII_DW,
  parameter int SV_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic             userclk2,
  input  logic             sys0_rst,
  input  logic [DW-1:0]    in_txd,
  input  logic             in_tx_en,
  input  logic             in_tx_er,
  input  logic             gmii_isolate,
  input  logic             tx_enable,
  input  logic             cnt_clr,
  input  logic             sticky_clr,
  output logic [DW-1:0]    out_txd,
  output logic             out_tx_en,
  output logic             out_tx_er,
  input  logic [SV_W-1:0]  status_vector,
  output logic [SV_W-1:0]  status_reg,
  output logic             status_any,
  output logic [SV_W-1:0]  status_sticky,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] link_fall_cnt
);

  localparam int PW = DW + 2;

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("gmii_tx_shim: STAGES must be within 1..4");
  end

  tx_state_e state_q, state_d;
  logic      gate_open, fwd, drop_inc, frame_inc, err_inc;
  logic      err_seen_q, err_seen_d;

  assign gate_open = tx_enable & ~gmii_isolate;

  always_ff @(posedge userclk2 or posedge sys0_rst) begin
    if (sys0_rst) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Gate is only sampled on the first cycle of a frame; later changes wait for the frame end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (!in_tx_en) state_d = ST_IDLE;
      ST_IDLE: if (in_tx_en) state_d = gate_open ? ST_PASS : ST_DROP;
      ST_PASS: if (!in_tx_en) state_d = ST_IDLE;
      ST_DROP: if (!in_tx_en) state_d = ST_IDLE;
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    fwd       = 1'b0;
    drop_inc  = 1'b0;
    frame_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fwd      = in_tx_en & gate_open;
        drop_inc = in_tx_en & ~gate_open;
      end
      ST_PASS: begin
        fwd       = in_tx_en;
        frame_inc = ~in_tx_en;
      end
      default: ;
    endcase
  end

  assign err_inc = frame_inc & err_seen_q;

  always_comb begin
    err_seen_d = err_seen_q | (fwd & in_tx_er);
    if (frame_inc) begin
      err_seen_d = 1'b0;
    end
  end

  always_ff @(posedge userclk2 or posedge sys0_rst) begin
    if (sys0_rst) begin
      err_seen_q <= 1'b0;
    end else begin
      err_seen_q <= err_seen_d;
    end
  end

  // tx_er outside a forwarded frame is squashed along with data and enable.
  logic [PW-1:0] stage0;
  logic [PW-1:0] pipe_q [STAGES];

  assign stage0 = fwd ? {in_txd, in_tx_en, in_tx_er} : '0;

  always_ff @(posedge userclk2 or posedge sys0_rst) begin
    if (sys0_rst) begin
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage0;
      for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {out_txd, out_tx_en, out_tx_er} = pipe_q[STAGES-1];

  logic [SV_W-1:0] status_reg_q, status_sticky_q;
  logic            link_fall;

  // Fall is seen on the edge where status_reg itself drops.
  assign link_fall = status_reg_q[LINK_BIT] & ~status_vector[LINK_BIT];

  always_ff @(posedge userclk2 or posedge sys0_rst) begin
    if (sys0_rst) begin
      status_reg_q    <= '0;
      status_sticky_q <= '0;
    end else begin
      status_reg_q    <= status_vector;
      status_sticky_q <= sticky_clr ? status_reg_q : (status_sticky_q | status_reg_q);
    end
  end

  assign status_reg    = status_reg_q;
  assign status_any    = |status_reg_q;
  assign status_sticky = status_sticky_q;

  gmii_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .userclk2 (userclk2), .sys0_rst (sys0_rst),
    .inc_i    (frame_inc), .clr_i   (cnt_clr), .cnt_o (frame_cnt)
  );

  gmii_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .userclk2 (userclk2), .sys0_rst (sys0_rst),
    .inc_i    (err_inc),   .clr_i   (cnt_clr), .cnt_o (err_cnt)
  );

  gmii_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .userclk2 (userclk2), .sys0_rst (sys0_rst),
    .inc_i    (drop_inc),  .clr_i   (cnt_clr), .cnt_o (drop_cnt)
  );

  gmii_sat_counter #(.CNT_W(CNT_W)) u_link_fall_cnt (
    .userclk2 (userclk2), .sys0_rst (sys0_rst),
    .inc_i    (link_fall), .clr_i   (cnt_clr), .cnt_o (link_fall_cnt)
  );

endmodule

// File: tb/tb_gmii_tx_shim.sv
// Bench for gmii_tx_shim with STAGES=2: frame-level model plus directed scenarios.
module tb_gmii_tx_shim;

  localparam int STAGES = 2;
  localparam int MAXC   = 65535;

  logic        userclk2;
  logic        sys0_rst;
  logic [7:0]  in_txd;
  logic        in_tx_en, in_tx_er, gmii_isolate, tx_enable, cnt_clr, sticky_clr;
  logic [7:0]  out_txd;
  logic        out_tx_en, out_tx_er;
  logic [15:0] status_vector, status_reg, status_sticky;
  logic        status_any;
  logic [15:0] frame_cnt, err_cnt, drop_cnt, link_fall_cnt;

  gmii_tx_shim #(.STAGES(STAGES), .DW(8), .SV_W(16), .CNT_W(16)) dut (
    .userclk2      (userclk2),
    .sys0_rst      (sys0_rst),
    .in_txd        (in_txd),
    .in_tx_en      (in_tx_en),
    .in_tx_er      (in_tx_er),
    .gmii_isolate  (gmii_isolate),
    .tx_enable     (tx_enable),
    .cnt_clr       (cnt_clr),
    .sticky_clr    (sticky_clr),
    .out_txd       (out_txd),
    .out_tx_en     (out_tx_en),
    .out_tx_er     (out_tx_er),
    .status_vector (status_vector),
    .status_reg    (status_reg),
    .status_any    (status_any),
    .status_sticky (status_sticky),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt),
    .drop_cnt      (drop_cnt),
    .link_fall_cnt (link_fall_cnt)
  );

  initial userclk2 = 1'b0;
  always #4 userclk2 = ~userclk2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_frame, m_err, m_drop, m_link;
  logic [15:0] m_st_reg, m_sticky;
  logic [9:0]  m_cur;
  logic [9:0]  m_dly[$];
  bit          armed, in_frame, fr_fwd, fr_err;

  function automatic int sat(input int c, input bit inc, input bit clr);
    if (clr) return 0;
    if (inc && c < MAXC) return c + 1;
    return c;
  endfunction

  task automatic model_reset();
    m_frame = 0; m_err = 0; m_drop = 0; m_link = 0;
    m_st_reg = '0; m_sticky = '0; m_cur = '0;
    armed = 0; in_frame = 0; fr_fwd = 0; fr_err = 0;
    m_dly = {};
    for (int i = 0; i < STAGES - 1; i++) m_dly.push_back(10'd0);
  endtask

  task automatic model_step();
    logic [9:0] s0;
    bit inc_f, inc_e, inc_d, gate, fall;
    s0 = '0; inc_f = 0; inc_e = 0; inc_d = 0;
    gate = tx_enable && !gmii_isolate;
    if (in_tx_en) begin
      if (!in_frame) begin
        in_frame = 1;
        fr_fwd   = armed && gate;
        fr_err   = 0;
        inc_d    = armed && !gate;
      end
      if (fr_fwd) begin
        s0     = {in_txd, 1'b1, in_tx_er};
        fr_err = fr_err || in_tx_er;
      end
    end else begin
      if (in_frame && fr_fwd) begin
        inc_f = 1;
        inc_e = fr_err;
      end
      in_frame = 0; fr_fwd = 0; armed = 1;
    end
    fall     = m_st_reg[0] && !status_vector[0];
    m_frame  = sat(m_frame, inc_f, cnt_clr);
    m_err    = sat(m_err, inc_e, cnt_clr);
    m_drop   = sat(m_drop, inc_d, cnt_clr);
    m_link   = sat(m_link, fall, cnt_clr);
    m_sticky = sticky_clr ? m_st_reg : (m_sticky | m_st_reg);
    m_st_reg = status_vector;
    m_dly.push_back(s0);
    m_cur    = m_dly.pop_front();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge userclk2 or posedge sys0_rst);
      if (sys0_rst) model_reset();
      else model_step();
    end
  end

  // ---------------- compare + output monitor ----------------
  int ncyc = 0, rise_cyc = 0, run = 0, last_run = 0, en_total = 0, er_n = 0;
  int er_offs[8];
  bit prev_en = 0;

  initial begin
    forever begin
      @(negedge userclk2);
      ncyc++;
      chk("tx_bus",        32'({out_txd, out_tx_en, out_tx_er}), 32'(m_cur));
      chk("status_reg",    32'(status_reg),    32'(m_st_reg));
      chk("status_any",    32'(status_any),    32'(|m_st_reg));
      chk("status_sticky", 32'(status_sticky), 32'(m_sticky));
      chk("frame_cnt",     32'(frame_cnt),     m_frame);
      chk("err_cnt",       32'(err_cnt),       m_err);
      chk("drop_cnt",      32'(drop_cnt),      m_drop);
      chk("link_fall_cnt", 32'(link_fall_cnt), m_link);
      if (out_tx_en) begin
        if (!prev_en) begin
          rise_cyc = ncyc;
          run = 0;
        end
        run++;
        en_total++;
        if (out_tx_er) begin
          er_offs[er_n % 8] = ncyc - rise_cyc;
          er_n++;
        end
      end else if (prev_en) begin
        last_run = run;
      end
      prev_en = out_tx_en;
    end
  end

  // ---------------- stimulus ----------------
  int in_start = 0;

  task automatic tick();
    @(negedge userclk2);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      in_tx_en = 0; in_tx_er = 0; in_txd = '0;
    end
  endtask

  task automatic clr_cnts();
    tick(); cnt_clr = 1;
    tick(); cnt_clr = 0;
  endtask

  task automatic send_frame(input int len, input int er1, input int er2,
                            input int chg_at, input logic chg_en, input logic chg_iso,
                            input logic clr_end);
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == chg_at) begin
        tx_enable    = chg_en;
        gmii_isolate = chg_iso;
      end
      if (i == 0) in_start = ncyc;
      in_txd   = i[7:0];
      in_tx_en = 1;
      in_tx_er = (i == er1) || (i == er2);
    end
    tick();
    in_tx_en = 0; in_tx_er = 0; in_txd = '0; cnt_clr = clr_end;
    tick();
    cnt_clr = 0;
    idle(12);
  endtask

  int base_en, base_er;
  int sv_seq[8] = '{1, 1, 9, 1, 0, 1, 0, 0};

  initial begin
    sys0_rst = 1; in_txd = '0; in_tx_en = 0; in_tx_er = 0;
    gmii_isolate = 0; tx_enable = 1; cnt_clr = 0; sticky_clr = 0;
    status_vector = '0;
    repeat (3) @(negedge userclk2);
    #1;
    chk("reset_outputs", 32'({out_txd, out_tx_en, out_tx_er, frame_cnt}), 32'd0);
    chk("reset_status",  32'({status_reg, status_sticky}), 32'd0);
    sys0_rst = 0;
    idle(4);

    // plain 64-byte frame
    send_frame(64, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    chk("t1_latency",  32'(rise_cyc - in_start), 32'd2);
    chk("t1_width",    32'(last_run), 32'd64);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_err_cnt",  32'(err_cnt), 32'd0);

    // tx_er on bytes 10 and 20
    clr_cnts();
    base_er = er_n;
    send_frame(64, 10, 20, -1, 1'b1, 1'b0, 1'b0);
    chk("t2_er_pulses", 32'(er_n - base_er), 32'd2);
    chk("t2_er_off_a",  32'(er_offs[base_er % 8]), 32'd10);
    chk("t2_er_off_b",  32'(er_offs[(base_er + 1) % 8]), 32'd20);
    chk("t2_err_cnt",   32'(err_cnt), 32'd1);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);

    // gate closed at frame start, opened mid-frame
    clr_cnts();
    tx_enable = 0;
    base_en = en_total;
    send_frame(40, -1, -1, 3, 1'b1, 1'b0, 1'b0);
    chk("t3_no_output", 32'(en_total - base_en), 32'd0);
    chk("t3_drop_cnt",  32'(drop_cnt), 32'd1);
    send_frame(30, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);

    // isolate mid-frame does not truncate; next frame dropped
    clr_cnts();
    send_frame(60, -1, -1, 5, 1'b1, 1'b1, 1'b0);
    chk("t4_width",     32'(last_run), 32'd60);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd1);
    send_frame(30, -1, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("t4_drop_cnt",  32'(drop_cnt), 32'd1);
    chk("t4_frame_cnt2", 32'(frame_cnt), 32'd1);
    gmii_isolate = 0;

    // reset mid-frame
    for (int i = 0; i < 31; i++) begin
      tick();
      in_txd = i[7:0]; in_tx_en = 1; in_tx_er = 0;
    end
    #2 sys0_rst = 1;
    #1;
    chk("t5_async_en",  32'(out_tx_en), 32'd0);
    chk("t5_async_txd", 32'(out_txd), 32'd0);
    base_en = en_total;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 2) sys0_rst = 0;
      in_txd = 8'(i + 31); in_tx_en = 1;
    end
    idle(6);
    chk("t5_no_output", 32'(en_total - base_en), 32'd0);
    chk("t5_cnts_zero", 32'({frame_cnt, drop_cnt}), 32'd0);
    send_frame(40, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    chk("t5_width",     32'(last_run), 32'd40);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);

    // status path
    clr_cnts();
    foreach (sv_seq[i]) begin
      tick();
      status_vector = 16'(sv_seq[i]);
    end
    idle(3);
    chk("t6_link_fall", 32'(link_fall_cnt), 32'd2);
    chk("t6_sticky3",   32'(status_sticky[3]), 32'd1);
    chk("t6_any_low",   32'(status_any), 32'd0);
    tick(); status_vector = 16'h0002;
    tick(); status_vector = 16'h0000; sticky_clr = 1;
    tick(); sticky_clr = 0;
    idle(2);
    chk("t6_sticky_clr", 32'(status_sticky), 32'h0002);
    tick(); status_vector = 16'h0001;
    idle(2);
    chk("t6_any_high",  32'(status_any), 32'd1);

    // cnt_clr on the frame-end cycle wins
    send_frame(20, -1, -1, -1, 1'b1, 1'b0, 1'b1);
    chk("t7_clr_wins",  32'(frame_cnt), 32'd0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gmii_tx_shim.md
Name: gmii_tx_shim

Overview:
- Parametrised GMII transmit shim between the MAC-side GMII TX bus and the 1000BASE-X/SGMII PCS/PMA core, in the userclk2 domain.
- Provides a configurable-depth retiming pipeline for the TX signals.
- Gates whole frames on a software enable and on PCS isolate, and never truncates a frame once started.
- Also registers the PCS status vector and maintains sticky status bits, per-frame statistics counters and link-drop statistics.

Parameters:
STAGES, 1, TX retiming register stages (legal 1..4); TX latency in cycles
DW, 8, GMII data width
SV_W, 16, PCS status_vector width; bit 0 is link status
CNT_W, 16, statistics counter width

Ports:
userclk2  in  1  125 MHz GMII clock; all logic on rising edge
sys0_rst  in  1  reset, asynchronous, active-high
in_txd  in  DW  MAC TX data
in_tx_en  in  1  MAC TX enable
in_tx_er  in  1  MAC TX error
gmii_isolate  in  1  PCS isolate request
tx_enable  in  1  software frame-gate enable
cnt_clr  in  1  synchronous clear of all counters
sticky_clr  in  1  synchronous clear of status_sticky
out_txd  out  DW  to PCS gmii_txd
out_tx_en  out  1  to PCS gmii_tx_en
out_tx_er  out  1  to PCS gmii_tx_er
status_vector  in  SV_W  raw PCS status
status_reg  out  SV_W  registered status
status_any  out  1  OR of status_reg
status_sticky  out  SV_W  per-bit sticky OR of status_reg
frame_cnt  out  CNT_W  frames forwarded
err_cnt  out  CNT_W  forwarded frames containing tx_er
drop_cnt  out  CNT_W  frames gated off
link_fall_cnt  out  CNT_W  falling edges of status_reg[0]

Behaviour:
- Reset: every output 0, pipeline registers 0, FSM in WAIT.
- Asserting reset mid-frame forces out_tx_en/out_tx_er/out_txd to 0 immediately (asynchronous).
- gate_open = tx_enable & ~gmii_isolate.
- FSM states: WAIT, IDLE, PASS, DROP.
  - WAIT → IDLE when in_tx_en=0. This guarantees that no partial frame is forwarded after reset.
  - IDLE with in_tx_en=1:
    - gate_open=1 → PASS; the current cycle is forwarded.
    - gate_open=0 → DROP; drop_cnt increments.
  - PASS with in_tx_en=0 → IDLE; frame_cnt increments. err_cnt also increments if tx_er was seen during the frame.
  - DROP with in_tx_en=0 → IDLE.
  - gate_open changes while in PASS or DROP are ignored until the frame ends (no truncation, no mid-frame admission).
- Forward condition (combinational on input cycle): fwd = (state==PASS & in_tx_en) | (state==IDLE & in_tx_en & gate_open).
- Stage-0 value when fwd=1: {in_txd, in_tx_en, in_tx_er}.
- Stage-0 value when fwd=0: all-zero. tx_er outside a forwarded frame is suppressed; carrier extension is not supported.
- Stage 0 feeds STAGES registers. Output equals stage-0 value exactly STAGES cycles later.
- err_seen flag:
  - set on in_tx_en & in_tx_er while in PASS or on the entry cycle;
  - cleared on frame end;
  - counted once per frame.
- Counters:
  - saturate at 2^CNT_W-1;
  - cnt_clr has priority over a same-cycle increment (result 0).
- Back-to-back frames need ≥1 cycle of in_tx_en=0 between them; GMII IFG guarantees this.
- Status path:
  - status_reg <= status_vector every cycle (1-cycle latency).
  - status_any = |status_reg.
  - status_sticky <= sticky_clr ? status_reg : status_sticky | status_reg. A bit asserted in the clear cycle survives the clear.
  - link_fall_cnt increments when status_reg[0] transitions 1→0. It saturates and is cleared by cnt_clr.

Decomposition:
- Shared package gmii_pkg:
  - FSM state enum (WAIT, IDLE, PASS, DROP);
  - GMII_DW=8 constant;
  - LINK_BIT=0 index;
  - STAGES legality bounds.
- One sub-module, gmii_sat_counter: CNT_W-wide saturating counter with inc and clr, clr priority. It is instantiated four times.

Test Plan:
- STAGES=2, tx_enable=1, 64-byte frame with txd=incrementing → identical bytes on out_txd 2 cycles later, out_tx_en width 64, frame_cnt=1, err_cnt=0.
- tx_er pulsed on bytes 10 and 20 of one frame → out_tx_er pulses at the same offsets, err_cnt=1 (not 2), frame_cnt=1.
- tx_enable=0 at frame start, raised mid-frame → no output activity, drop_cnt=1. The next frame is forwarded, frame_cnt=1.
- gmii_isolate asserted at byte 5 of a forwarded 60-byte frame → all 60 bytes emitted. A second frame during isolate gives drop_cnt=1.
- Reset asserted at byte 30 with in_tx_en held high 20 more cycles → outputs 0 at once, nothing forwarded until in_tx_en falls. The following frame is forwarded in full.
- status_vector toggles bit0 1→0 twice, bit3 pulses one cycle → link_fall_cnt=2, status_sticky[3]=1 until sticky_clr, status_any tracks status_reg. cnt_clr together with a frame end gives frame_cnt=0.
